mod_alu_secuencial: RTL and testbench
=====================================

Name: mod_alu_secuencial

Overview:
Registered, multi-cycle successor to the team's combinational n-bit ALU for the calculator datapath. Extends the operation set to 8 ops (adds XOR, shifts, unsigned multiply), registers the result and NZCV flags, and uses a start/ready/valid handshake toward the calculator control FSM. Multiply is iterative shift-add, taking n_bits cycles; every other op completes in one cycle.

Parameters:
n_bits, 8, operand/result width (>=4).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
entrada_a  input  n_bits  operand A, sampled when inicio accepted
entrada_b  input  n_bits  operand B (shift amount for shifts), sampled when inicio accepted
operacion  input  3  opcode, sampled when inicio accepted
inicio  input  1  start request; accepted only when listo=1
listo  output  1  block idle, can accept inicio
valido  output  1  one-cycle pulse: resultado/resultado_alto/flags updated
resultado  output  n_bits  result (low half of product for multiply)
resultado_alto  output  n_bits  high half of product; 0 for non-multiply ops
flags  output  4  {N,Z,C,V}, registered with result

Behaviour:
- Reset (synchronous, active-high): state=REPOSO, listo=1, valido=0, resultado=0, resultado_alto=0, flags=0, multiply registers cleared. Reset asserted mid-multiply aborts it; no valido issued.
- Opcodes: 000 A+B; 001 A-B (A+~B+1); 010 A&B; 011 A|B; 100 A^B; 101 A<<B; 110 A>>B (logical); 111 A*B unsigned, 2*n_bits product.
- States: REPOSO, MULT. Inputs latched on the edge where inicio=1 and listo=1 (edge k).
- Ops 000-110: result and flags registered at edge k; valido=1 for the cycle after edge k; state stays REPOSO, listo stays 1, so back-to-back inicio every cycle is allowed.
- Op 111: edge k loads multiplicand, multiplier and a 2n-bit accumulator=0, counter=0; state->MULT, listo=0. Each MULT edge: if multiplier LSB=1, add the shifted multiplicand into the accumulator; shift the multiplicand left and the multiplier right; counter++. On the n_bits-th MULT edge (edge k+n_bits): write the product to resultado_alto:resultado and flags, state->REPOSO. In the cycle after that edge, listo=1 and valido=1.
- inicio while listo=0: ignored, no side effects. Operand/opcode changes while busy: no effect.
- resultado_alto is forced to 0 on every non-multiply result.
- Outputs hold their last values between valido pulses.
- Flags:
  - N = resultado[n_bits-1] (0 for multiply).
  - Z = 1 iff the full result is 0 (for multiply, all 2*n_bits bits).
  - C: add = carry-out; sub = 1 when A>=B unsigned (no borrow); shifts = last bit shifted out, 0 if B=0 or B>=n_bits; multiply = (resultado_alto!=0); logic ops = 0.
  - V: signed overflow for add/sub (operand signs equal / differ and result sign differs from A); 0 otherwise.
- Shifts: amount is the full unsigned value of B. If B>=n_bits, result is 0.

Optional Feature:
Macro ALU_SATURACION_EN.
- Defined: for ops 000/001, when V=1 the result clamps to the signed extreme: 0x7F..F on positive overflow, 0x80..0 on negative overflow. N and Z are computed from the clamped value. C and V are computed from the unclamped operation, so V=1 is still reported.
- Undefined: add/sub wrap modulo 2^n_bits. All other ops are identical in both builds.

Test Plan:
- n_bits=8, add A=0x7F B=0x01 -> next cycle valido=1, resultado=0x80, NZCV=1001 (with ALU_SATURACION_EN: resultado=0x7F, NZCV=0001).
- sub A=0x05 B=0x05 -> resultado=0x00, NZCV=0110. Then sub A=0x03 B=0x05 on the following cycle (back-to-back) -> resultado=0xFE, NZCV=1000, valido high both cycles.
- mul A=0xFF B=0xFF, inicio at edge k -> listo=0 for 8 cycles, valido=1 and listo=1 in the cycle after edge k+8, resultado_alto=0xFE, resultado=0x01, NZCV=0010.
- shl A=0x81 B=1 -> resultado=0x02, C=1. shl A=0x81 B=8 -> resultado=0x00, Z=1, C=0. shr A=0x81 B=1 -> resultado=0x40, C=1.
- During a multiply, pulse inicio with op=000 -> ignored; only the multiply valido appears. Assert reset at MULT cycle 4 -> next cycle listo=1, all outputs 0, no valido.
- xor A=0xAA B=0xAA -> resultado=0x00, Z=1, resultado_alto=0 (issued after a prior multiply that left resultado_alto nonzero).

Source files
------------

// File: rtl/mod_alu_secuencial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_alu_secuencial : registered 8-op ALU, iterative shift-add multiply.
// Optional macro ALU_SATURACION_EN clamps add/sub on signed overflow. Rev 1.0
// ---------------------------------------------------------------------------
module mod_alu_secuencial #(
  parameter int n_bits = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [n_bits-1:0] entrada_a,
  input  logic [n_bits-1:0] entrada_b,
  input  logic [2:0]        operacion,
  input  logic              inicio,
  output logic              listo,
  output logic              valido,
  output logic [n_bits-1:0] resultado,
  output logic [n_bits-1:0] resultado_alto,
  output logic [3:0]        flags
);

  localparam int          c_cw     = $clog2(n_bits) + 1;
  localparam logic [c_cw-1:0]   c_ultimo = c_cw'(n_bits - 1);
  localparam logic [n_bits-1:0] c_ancho  = n_bits[n_bits-1:0];
  localparam logic [2:0] c_op_add = 3'b000, c_op_sub = 3'b001, c_op_and = 3'b010,
                         c_op_or  = 3'b011, c_op_xor = 3'b100, c_op_shl = 3'b101,
                         c_op_shr = 3'b110, c_op_mul = 3'b111;

  typedef enum logic [0:0] {REPOSO = 1'b0, MULT = 1'b1} estado_t;

  estado_t                 r_estado, w_estado_sig;
  logic [2*n_bits-1:0]     r_mcand, r_acc, w_acc_sig;
  logic [n_bits-1:0]       r_mplier;
  logic [c_cw-1:0]         r_cnt;
  logic                    r_valido;
  logic [n_bits-1:0]       r_res, r_res_alto;
  logic [3:0]              r_flags;
  logic                    w_acepta, w_fin;

  logic [n_bits:0]         w_suma, w_resta;
  logic [2*n_bits-1:0]     w_shl, w_shr;
  logic                    w_fuera;
  logic [n_bits-1:0]       w_res;
  logic                    w_c, w_v;

  assign w_suma  = {1'b0, entrada_a} + {1'b0, entrada_b};
  assign w_resta = {1'b0, entrada_a} + {1'b0, ~entrada_b} + {{n_bits{1'b0}}, 1'b1};
  // Widened shifts keep the last bit shifted out at a fixed position.
  assign w_shl   = {{n_bits{1'b0}}, entrada_a} << entrada_b;
  assign w_shr   = {entrada_a, {n_bits{1'b0}}} >> entrada_b;
  assign w_fuera = (entrada_b >= c_ancho);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (operacion)
      c_op_add: begin
        w_res = w_suma[n_bits-1:0];
        w_c   = w_suma[n_bits];
        w_v   = (entrada_a[n_bits-1] == entrada_b[n_bits-1]) &&
                (w_suma[n_bits-1] != entrada_a[n_bits-1]);
      end
      c_op_sub: begin
        w_res = w_resta[n_bits-1:0];
        w_c   = w_resta[n_bits];
        w_v   = (entrada_a[n_bits-1] != entrada_b[n_bits-1]) &&
                (w_resta[n_bits-1] != entrada_a[n_bits-1]);
      end
      c_op_and: w_res = entrada_a & entrada_b;
      c_op_or:  w_res = entrada_a | entrada_b;
      c_op_xor: w_res = entrada_a ^ entrada_b;
      c_op_shl: if (!w_fuera) begin
        w_res = w_shl[n_bits-1:0];
        w_c   = w_shl[n_bits];
      end
      c_op_shr: if (!w_fuera) begin
        w_res = w_shr[2*n_bits-1:n_bits];
        w_c   = w_shr[n_bits-1];
      end
      default: ;
    endcase
`ifdef ALU_SATURACION_EN
    if (((operacion == c_op_add) || (operacion == c_op_sub)) && w_v)
      w_res = entrada_a[n_bits-1] ? {1'b1, {(n_bits-1){1'b0}}} : {1'b0, {(n_bits-1){1'b1}}};
`else
    w_res = w_res;
`endif
  end

  assign w_acc_sig = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) r_estado <= REPOSO;
    else       r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    w_acepta     = 1'b0;
    w_fin        = 1'b0;
    case (r_estado)
      REPOSO: if (inicio) begin
        w_acepta = 1'b1;
        if (operacion == c_op_mul) w_estado_sig = MULT;
      end
      MULT: if (r_cnt == c_ultimo) begin
        w_fin        = 1'b1;
        w_estado_sig = REPOSO;
      end
      default: w_estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_valido   <= 1'b0;
      r_res      <= '0;
      r_res_alto <= '0;
      r_flags    <= '0;
    end else begin
      r_valido <= 1'b0;
      if (w_acepta) begin
        if (operacion == c_op_mul) begin
          r_mcand  <= {{n_bits{1'b0}}, entrada_a};
          r_mplier <= entrada_b;
          r_acc    <= '0;
          r_cnt    <= '0;
        end else begin
          r_res      <= w_res;
          r_res_alto <= '0;
          r_flags    <= {w_res[n_bits-1], (w_res == '0), w_c, w_v};
          r_valido   <= 1'b1;
        end
      end
      if (r_estado == MULT) begin
        r_acc    <= w_acc_sig;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_fin) begin
          r_res      <= w_acc_sig[n_bits-1:0];
          r_res_alto <= w_acc_sig[2*n_bits-1:n_bits];
          r_flags    <= {1'b0, (w_acc_sig == '0),
                         (w_acc_sig[2*n_bits-1:n_bits] != '0), 1'b0};
          r_valido   <= 1'b1;
        end
      end
    end
  end

  assign listo          = (r_estado == REPOSO);
  assign valido         = r_valido;
  assign resultado      = r_res;
  assign resultado_alto = r_res_alto;
  assign flags          = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_mod_alu_secuencial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mod_alu_secuencial : directed + random checks against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_mod_alu_secuencial;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset, inicio, listo, valido;
  logic [N-1:0] entrada_a, entrada_b, resultado, resultado_alto;
  logic [2:0]   operacion;
  logic [3:0]   flags;

  int tests = 0;
  int fails = 0;

  // expected outputs after the most recent edge
  int m_busy = 0;
  int m_pend = 0;
  int e_val = 0, e_listo = 1, e_res = 0, e_hi = 0, e_flags = 0;

  mod_alu_secuencial #(.n_bits(N)) dut (
    .clk(clk), .reset(reset), .entrada_a(entrada_a), .entrada_b(entrada_b),
    .operacion(operacion), .inicio(inicio), .listo(listo), .valido(valido),
    .resultado(resultado), .resultado_alto(resultado_alto), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic calc(input int op, input int a, input int b);
    int r, c, v, sa, sb, s;
    r = 0; c = 0; v = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: begin s = a + b; r = s % 256; c = (s > 255); s = sa + sb; v = (s > 127 || s < -128); end
      1: begin r = (a - b + 256) % 256; c = (a >= b); s = sa - sb; v = (s > 127 || s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: if (b == 0) r = a;
         else if (b < N) begin r = (a << b) % 256; c = (a >> (N - b)) % 2; end
      6: if (b == 0) r = a;
         else if (b < N) begin r = a >> b; c = (a >> (b - 1)) % 2; end
      default: ;
    endcase
`ifdef ALU_SATURACION_EN
    if (op < 2 && v == 1) r = (sa < 0) ? 128 : 127;
`endif
    e_res   = r;
    e_hi    = 0;
    e_flags = ((r >= 128) ? 8 : 0) + ((r == 0) ? 4 : 0) + c * 2 + v;
  endtask

  task automatic model_step();
    if (reset) begin
      m_busy = 0; e_val = 0; e_res = 0; e_hi = 0; e_flags = 0;
    end else begin
      e_val = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          e_res   = m_pend % 256;
          e_hi    = m_pend / 256;
          e_flags = ((m_pend == 0) ? 4 : 0) + ((e_hi != 0) ? 2 : 0);
          e_val   = 1;
        end
      end else if (inicio) begin
        if (operacion == 3'd7) begin
          m_busy = N;
          m_pend = int'(entrada_a) * int'(entrada_b);
        end else begin
          calc(int'(operacion), int'(entrada_a), int'(entrada_b));
          e_val = 1;
        end
      end
    end
    e_listo = (m_busy == 0) ? 1 : 0;
  endtask

  task automatic comparar();
    chk("valido", int'(valido), e_val);
    chk("listo", int'(listo), e_listo);
    chk("resultado", int'(resultado), e_res);
    chk("resultado_alto", int'(resultado_alto), e_hi);
    chk("flags", int'(flags), e_flags);
  endtask

  // Drive at negedge, model the edge, then compare at the next negedge.
  task automatic ciclo(input logic r, input logic i, input logic [2:0] op,
                       input logic [N-1:0] a, input logic [N-1:0] b);
    reset = r; inicio = i; operacion = op; entrada_a = a; entrada_b = b;
    @(posedge clk);
    model_step();
    @(negedge clk);
    comparar();
  endtask

  initial begin
    reset = 1'b1; inicio = 1'b0; operacion = '0; entrada_a = '0; entrada_b = '0;
    @(negedge clk);
    ciclo(1, 0, 0, 0, 0);
    chk("lit_reset_listo", int'(listo), 1);
    chk("lit_reset_res", int'(resultado), 0);
    ciclo(0, 0, 0, 0, 0);

    ciclo(0, 1, 3'd0, 8'h7F, 8'h01);
`ifdef ALU_SATURACION_EN
    chk("lit_add_res", int'(resultado), 'h7F);
    chk("lit_add_flags", int'(flags), 'b0001);
`else
    chk("lit_add_res", int'(resultado), 'h80);
    chk("lit_add_flags", int'(flags), 'b1001);
`endif
    ciclo(0, 1, 3'd1, 8'h05, 8'h05);
    chk("lit_sub0_flags", int'(flags), 'b0110);
    ciclo(0, 1, 3'd1, 8'h03, 8'h05);
    chk("lit_sub1_res", int'(resultado), 'hFE);
    chk("lit_sub1_flags", int'(flags), 'b1000);
    chk("lit_sub1_valido", int'(valido), 1);

    ciclo(0, 1, 3'd7, 8'hFF, 8'hFF);
    chk("lit_mul_busy", int'(listo), 0);
    for (int k = 0; k < N - 1; k++) ciclo(0, 1, 3'd0, 8'h11, 8'h22);
    chk("lit_mul_still_busy", int'(listo), 0);
    ciclo(0, 0, 3'd0, 0, 0);
    chk("lit_mul_valido", int'(valido), 1);
    chk("lit_mul_hi", int'(resultado_alto), 'hFE);
    chk("lit_mul_lo", int'(resultado), 'h01);
    chk("lit_mul_flags", int'(flags), 'b0010);

    ciclo(0, 1, 3'd4, 8'hAA, 8'hAA);
    chk("lit_xor_hi", int'(resultado_alto), 0);
    chk("lit_xor_flags", int'(flags), 'b0100);
    ciclo(0, 1, 3'd5, 8'h81, 8'd1);
    chk("lit_shl1", int'(resultado), 'h02);
    chk("lit_shl1_c", int'(flags[1]), 1);
    ciclo(0, 1, 3'd5, 8'h81, 8'd8);
    chk("lit_shl8_flags", int'(flags), 'b0100);
    ciclo(0, 1, 3'd6, 8'h81, 8'd1);
    chk("lit_shr1", int'(resultado), 'h40);
    chk("lit_shr1_c", int'(flags[1]), 1);

    ciclo(0, 1, 3'd7, 8'h0F, 8'h13);
    for (int k = 0; k < 3; k++) ciclo(0, 0, 3'd0, 0, 0);
    ciclo(1, 0, 3'd0, 0, 0);
    chk("lit_abort_listo", int'(listo), 1);
    chk("lit_abort_valido", int'(valido), 0);
    chk("lit_abort_res", int'(resultado), 0);
    for (int k = 0; k < N + 2; k++) ciclo(0, 0, 3'd0, 0, 0);

    for (int k = 0; k < 3000; k++) begin
      logic [2:0] op;
      logic [N-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = N'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, N + 1)) : N'($urandom);
      ciclo(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
